alu_issue: RTL
==============

Name: alu_issue

Overview:
- Operand-issue and writeback stage wrapped around the combinational 8-bit ALU (op 000 add, 001 sub, 010 mul, 011 div, 100 and, 101 or, 110 not-a, 111 xor).
- Accepts commands over a valid/ready handshake and reads operands from a small internal register file. It drives the ALU inputs, captures the ALU result, writes it back to the file, and presents it with flags on a second valid/ready handshake.
- Sits between the command source (testbench or later sequencer) and the ALU.

Parameters:
- WIDTH, 8, data width of registers, ALU operands and result.
- REGS, 4, number of register-file entries.
- AW, 2, register address width; REGS = 2**AW.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  stage can accept a command.
- cmd_load  in  1  1 = load immediate; 0 = ALU operation.
- cmd_op  in  3  ALU opcode; ignored when cmd_load=1.
- cmd_rd  in  AW  destination register.
- cmd_rs1  in  AW  source register for operand a.
- cmd_rs2  in  AW  source register for operand b.
- cmd_imm  in  WIDTH  immediate value; used only when cmd_load=1.
- alu_a  out  WIDTH  operand a to ALU.
- alu_b  out  WIDTH  operand b to ALU.
- alu_op  out  3  opcode to ALU.
- alu_y  in  WIDTH  combinational ALU result.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  WIDTH  value written to cmd_rd.
- res_zero  out  1  res_data == 0.
- res_dz  out  1  divide-by-zero occurred.
- dbg_sel  in  AW  register-file debug read address.
- dbg_data  out  WIDTH  combinational read of rf[dbg_sel].

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; all rf entries 0.
  - alu_a, alu_b, alu_op, res_data = 0; res_valid, res_zero, res_dz = 0.
  - Any in-flight command is discarded with no writeback.
  - cmd_ready reads 1 in the first cycle after release.
- States: IDLE, ISSUE, RESP.
- cmd_ready = (state==IDLE), combinational from state only.
- Accept means cmd_valid && cmd_ready at a rising edge. Only one command is in flight at a time.
- IDLE, on accept with cmd_load=0:
  - Register alu_a=rf[cmd_rs1], alu_b=rf[cmd_rs2], alu_op=cmd_op.
  - Latch rd and a div-by-zero flag dz = (cmd_op==3'b011 && rf[cmd_rs2]==0).
  - Go to ISSUE.
- IDLE, on accept with cmd_load=1:
  - rf[cmd_rd]=cmd_imm; res_data=cmd_imm; res_zero=(cmd_imm==0); res_dz=0; res_valid=1.
  - Go to RESP. alu_* hold their previous values.
- ISSUE (exactly one cycle):
  - alu_a, alu_b and alu_op are stable, so alu_y settles.
  - At the edge, the result is r = dz ? all-ones : alu_y. All-ones is 8'hFF for WIDTH=8; alu_y is ignored on divide-by-zero.
  - rf[rd]=r; res_data=r; res_zero=(r==0); res_dz=dz; res_valid=1. Go to RESP.
- RESP:
  - res_valid=1 and res_data, res_zero, res_dz are held stable until res_ready is sampled high.
  - On res_valid && res_ready: res_valid=0, go to IDLE. res_data and flags hold their values after the handshake.
  - cmd_ready=0 throughout RESP. Commands presented then are not accepted and must be held by the source.
- Latency, accept edge to res_valid high: ALU command 2 cycles; load 1 cycle. With res_ready tied high, throughput is one ALU command per 3 cycles and one load per 2 cycles.
- Hazards:
  - Writeback completes before IDLE is re-entered, so the next command reads updated rf.
  - rd equal to rs1 or rs2 is legal; operands are sampled at accept, before writeback.
- Arithmetic:
  - The ALU truncates results to WIDTH; add, sub and mul wrap modulo 2**WIDTH with no carry flag.
  - op 110 uses only alu_a; alu_b is still driven from rf[rs2].
- alu_a, alu_b and alu_op change only on an ALU-command accept or on reset.
- dbg_data is combinational and reflects a writeback from the edge it occurs.

Test Plan:
- Load r0=8'h07, then load r1=8'h03 -> each gives res_valid 1 cycle after accept with res_data 07 then 03, res_zero=0, dbg_data(r0)=07, dbg_data(r1)=03.
- Add r2=r0+r1, then sub r3=r1-r0 -> res_data 8'h0A, then 8'hFC (wrap); res_valid 2 cycles after accept; alu_op 000 then 001 during ISSUE.
- Mul r2=r0*r1 gives 8'h15. Then load r3=0 and div r2=r0/r3 -> res_data 8'hFF, res_dz=1, rf[2]=FF. Div r2=r0/r1 -> 8'h02, res_dz=0.
- Xor r0=r0^r0 -> res_data 0, res_zero=1, rf[0]=0. Also exercises rd==rs1==rs2.
- Hold res_ready=0 for 5 cycles with cmd_valid=1 -> res_valid stays 1, res_data stable, cmd_ready=0, no second accept. Raise res_ready -> next cycle IDLE and the pending command is accepted.
- Assert rst_n=0 during ISSUE of an add -> immediately state IDLE, res_valid=0, all rf 0, alu_* 0. After release, cmd_ready=1 and there is no writeback of the aborted command.

Source files
------------

// File: rtl/alu_issue.sv
// Operand-issue / writeback stage around an external combinational ALU.
// Commands read a small register file, drive the ALU, and return results over a valid/ready port.
module alu_issue #(
  parameter int WIDTH = 8,
  parameter int REGS  = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic [2:0]       cmd_op,
  input  logic [AW-1:0]    cmd_rd,
  input  logic [AW-1:0]    cmd_rs1,
  input  logic [AW-1:0]    cmd_rs2,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_y,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_zero,
  output logic             res_dz,
  input  logic [AW-1:0]    dbg_sel,
  output logic [WIDTH-1:0] dbg_data
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // the producer holds payload stable while valid is high and ready is low.
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] rf_q [REGS];
  logic [WIDTH-1:0] rf_d [REGS];
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_zero_q, res_zero_d;
  logic             res_dz_q, res_dz_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] wb_val;

  always_comb begin
    state_d     = state_q;
    rf_d        = rf_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    rd_d        = rd_q;
    dz_d        = dz_q;
    res_data_d  = res_data_q;
    res_zero_d  = res_zero_q;
    res_dz_d    = res_dz_q;
    res_valid_d = res_valid_q;
    // Divide-by-zero forces all-ones regardless of what the ALU produces.
    wb_val      = dz_q ? {WIDTH{1'b1}} : alu_y;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_load) begin
            rf_d[cmd_rd] = cmd_imm;
            res_data_d   = cmd_imm;
            res_zero_d   = (cmd_imm == '0);
            res_dz_d     = 1'b0;
            res_valid_d  = 1'b1;
            state_d      = S_RESP;
          end else begin
            alu_a_d  = rf_q[cmd_rs1];
            alu_b_d  = rf_q[cmd_rs2];
            alu_op_d = cmd_op;
            rd_d     = cmd_rd;
            dz_d     = (cmd_op == 3'b011) && (rf_q[cmd_rs2] == '0);
            state_d  = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        rf_d[rd_q]  = wb_val;
        res_data_d  = wb_val;
        res_zero_d  = (wb_val == '0);
        res_dz_d    = dz_q;
        res_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      for (int i = 0; i < REGS; i++) rf_q[i] <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      rd_q        <= '0;
      dz_q        <= 1'b0;
      res_data_q  <= '0;
      res_zero_q  <= 1'b0;
      res_dz_q    <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rf_q        <= rf_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      rd_q        <= rd_d;
      dz_q        <= dz_d;
      res_data_q  <= res_data_d;
      res_zero_q  <= res_zero_d;
      res_dz_q    <= res_dz_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_zero  = res_zero_q;
  assign res_dz    = res_dz_q;
  assign dbg_data  = rf_q[dbg_sel];

endmodule
